vc_link_arbiter: RTL and testbench

// - Shares one physical output link between N_VIRT_CHN virtual-channel buffer outputs with wormhole locking.
// - Selects a HEAD flit round-robin and holds the link for that VC until its TAIL flit is transferred.
// - Single-flit packets release the link immediately.
// - Sits between the per-VC flit buffers of an input port and the router output.

---
 rtl/vc_link_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vc_link_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_link_arbiter.sv
// Wormhole link arbiter: round-robin HEAD selection across virtual channels, link held until TAIL.
// Optional stall watchdog enabled by defining VC_LINK_ARB_WATCHDOG_EN.
module vc_link_arbiter #(
  parameter int unsigned N_VIRT_CHN  = 3,
  parameter int unsigned FLIT_WIDTH  = 34,
  parameter int unsigned PKT_SZ_W    = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] vc_fdata_i,
  input  logic [N_VIRT_CHN-1:0]            vc_valid_i,
  output logic [N_VIRT_CHN-1:0]            vc_ready_o,
  output logic [FLIT_WIDTH-1:0]            link_fdata_o,
  output logic                             link_valid_o,
  input  logic                             link_ready_i,
  output logic [$clog2(N_VIRT_CHN)-1:0]    link_vc_id_o,
  output logic                             err_proto_o,
  output logic                             err_timeout_o
);

  localparam int unsigned VC_W = $clog2(N_VIRT_CHN);
  localparam logic [1:0]  TYPE_HEAD = 2'd0;
  localparam logic [1:0]  TYPE_TAIL = 2'd2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0]   owner_q, owner_d;
  logic              err_proto_q, err_proto_d;

  logic [N_VIRT_CHN-1:0] is_head;
  logic [N_VIRT_CHN-1:0] bad_idle;
  logic                  any_elig;
  logic [VC_W-1:0]       winner;
  logic [VC_W-1:0]       rr_idx;
  logic [VC_W-1:0]       sel_vc;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic [1:0]            sel_type;
  logic [PKT_SZ_W-1:0]   sel_size;
  logic                  xfer;

  function automatic logic [VC_W-1:0] wrap_inc(input logic [VC_W-1:0] v);
    return (v == VC_W'(N_VIRT_CHN - 1)) ? '0 : v + VC_W'(1);
  endfunction

  // Per-VC flit type decode
  always_comb begin : field_decode
    is_head  = '0;
    bad_idle = '0;
    for (int k = 0; k < int'(N_VIRT_CHN); k++) begin
      is_head[k]  = (vc_fdata_i[k*FLIT_WIDTH + FLIT_WIDTH - 1 -: 2] == TYPE_HEAD);
      bad_idle[k] = vc_valid_i[k] && !is_head[k];
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr wins
  always_comb begin : rr_pick
    any_elig = 1'b0;
    winner   = rr_ptr_q;
    rr_idx   = '0;
    for (int i = int'(N_VIRT_CHN) - 1; i >= 0; i--) begin
      rr_idx = VC_W'((int'(rr_ptr_q) + i) % int'(N_VIRT_CHN));
      if (vc_valid_i[rr_idx] && is_head[rr_idx]) begin
        any_elig = 1'b1;
        winner   = rr_idx;
      end
    end
  end

  // Next state and combinational link datapath
  always_comb begin : fsm_comb
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    err_proto_d  = err_proto_q;
    vc_ready_o   = '0;
    link_valid_o = 1'b0;
    link_fdata_o = '0;
    link_vc_id_o = '0;

    sel_vc   = (state_q == S_LOCKED) ? owner_q : winner;
    sel_flit = vc_fdata_i[int'(sel_vc)*FLIT_WIDTH +: FLIT_WIDTH];
    sel_type = sel_flit[FLIT_WIDTH-1 -: 2];
    sel_size = sel_flit[FLIT_WIDTH-3 -: PKT_SZ_W];

    if (!arst) begin
      link_valid_o = (state_q == S_LOCKED) ? vc_valid_i[owner_q] : any_elig;
      link_vc_id_o = sel_vc;
    end
    if (link_valid_o) begin
      link_fdata_o = sel_flit;
    end
    xfer = link_valid_o && link_ready_i;
    if (xfer) begin
      vc_ready_o[sel_vc] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (|bad_idle) begin
          err_proto_d = 1'b1;
        end
        if (xfer) begin
          if (sel_size != '0) begin
            state_d = S_LOCKED;
            owner_d = winner;
          end else begin
            rr_ptr_d = wrap_inc(winner);
          end
        end
      end
      S_LOCKED: begin
        if (vc_valid_i[owner_q] && sel_type == TYPE_HEAD) begin
          err_proto_d = 1'b1;
        end
        if (xfer && sel_type == TYPE_TAIL) begin
          state_d  = S_IDLE;
          rr_ptr_d = wrap_inc(owner_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : state_reg
    if (arst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign err_proto_o = err_proto_q;

`ifdef VC_LINK_ARB_WATCHDOG_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_to_q, err_to_d;

  // Saturating count of cycles the lock owner has nothing to send
  always_comb begin : wdog_comb
    stall_d  = stall_q;
    err_to_d = err_to_q;
    if (state_q != S_LOCKED || state_d != S_LOCKED || xfer) begin
      stall_d = '0;
    end else if (!vc_valid_i[owner_q] && stall_q != STALL_W'(TIMEOUT_CYC)) begin
      stall_d = stall_q + STALL_W'(1);
    end
    if (stall_d == STALL_W'(TIMEOUT_CYC)) begin
      err_to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin : wdog_reg
    if (arst) begin
      stall_q  <= '0;
      err_to_q <= 1'b0;
    end else begin
      stall_q  <= stall_d;
      err_to_q <= err_to_d;
    end
  end

  assign err_timeout_o = err_to_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign err_timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Directed self-checking bench for vc_link_arbiter (N=3, 34-bit flits, TIMEOUT_CYC=4).
// Watchdog checks follow VC_LINK_ARB_WATCHDOG_EN.
module tb_vc_link_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned FW = 34;
  localparam int unsigned SW = 8;
  localparam int unsigned TO = 4;

  localparam logic [1:0] H = 2'd0;
  localparam logic [1:0] B = 2'd1;
  localparam logic [1:0] T = 2'd2;

  logic          clk = 1'b0;
  logic          arst;
  logic [FW-1:0] f0, f1, f2;
  logic [N*FW-1:0] vc_fdata;
  logic [N-1:0]  vc_valid;
  logic [N-1:0]  vc_ready;
  logic [FW-1:0] link_fdata;
  logic          link_valid;
  logic          link_ready;
  logic [1:0]    link_vc_id;
  logic          err_proto;
  logic          err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign vc_fdata = {f2, f1, f0};

  vc_link_arbiter #(
    .N_VIRT_CHN (N),
    .FLIT_WIDTH (FW),
    .PKT_SZ_W   (SW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .vc_fdata_i   (vc_fdata),
    .vc_valid_i   (vc_valid),
    .vc_ready_o   (vc_ready),
    .link_fdata_o (link_fdata),
    .link_valid_o (link_valid),
    .link_ready_i (link_ready),
    .link_vc_id_o (link_vc_id),
    .err_proto_o  (err_proto),
    .err_timeout_o(err_timeout)
  );

  function automatic logic [FW-1:0] flit(input logic [1:0] t, input logic [7:0] sz,
                                         input logic [23:0] pl);
    return {t, sz, pl};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic expect_link(input string tag, input logic v, input logic [2:0] rdy,
                             input logic [1:0] id, input logic [FW-1:0] d);
    check({tag, "_valid"}, 64'(link_valid), 64'(v));
    check({tag, "_ready"}, 64'(vc_ready), 64'(rdy));
    check({tag, "_id"},    64'(link_vc_id), 64'(id));
    check({tag, "_data"},  64'(link_fdata), 64'(d));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic reset_pulse;
    arst     = 1'b1;
    vc_valid = '0;
    tick();
    arst     = 1'b0;
  endtask

  initial begin
    arst       = 1'b1;
    vc_valid   = '0;
    f0         = '0;
    f1         = '0;
    f2         = '0;
    link_ready = 1'b1;
    tick();
    tick();

    // outputs forced quiet while reset is asserted even with heads waiting
    vc_valid = 3'b111;
    f0 = flit(H, 8'd0, 24'h000111);
    f1 = flit(H, 8'd0, 24'h000222);
    f2 = flit(H, 8'd0, 24'h000333);
    settle();
    expect_link("rst", 1'b0, 3'b000, 2'd0, '0);
    check("rst_err_proto", 64'(err_proto), 64'(0));
    check("rst_err_timeout", 64'(err_timeout), 64'(0));
    tick();

    // single-flit head from VC1 transfers in the first cycle, rr_ptr -> 2
    arst     = 1'b0;
    vc_valid = 3'b010;
    f1 = flit(H, 8'd0, 24'h0000A1);
    settle();
    expect_link("t1", 1'b1, 3'b010, 2'd1, flit(H, 8'd0, 24'h0000A1));
    tick();
    vc_valid = 3'b101;
    f0 = flit(H, 8'd0, 24'h0000B0);
    f2 = flit(H, 8'd0, 24'h0000B2);
    settle();
    expect_link("t1_rr", 1'b1, 3'b100, 2'd2, flit(H, 8'd0, 24'h0000B2));
    tick();

    // all three VCs with single-flit heads: grant order 0,1,2,0,1,2
    reset_pulse();
    vc_valid = 3'b111;
    f0 = flit(H, 8'd0, 24'h000C00);
    f1 = flit(H, 8'd0, 24'h000C11);
    f2 = flit(H, 8'd0, 24'h000C22);
    for (int i = 0; i < 6; i++) begin
      settle();
      check("t2_id", 64'(link_vc_id), 64'(i % 3));
      check("t2_ready", 64'(vc_ready), 64'(3'b001 << (i % 3)));
      tick();
    end

    // 3-flit packet on VC0 while VC2 waits with a head
    reset_pulse();
    vc_valid = 3'b101;
    f0 = flit(H, 8'd2, 24'h0000D0);
    f2 = flit(H, 8'd0, 24'h0000D2);
    settle();
    expect_link("t3_head", 1'b1, 3'b001, 2'd0, flit(H, 8'd2, 24'h0000D0));
    tick();
    f0 = flit(B, 8'd0, 24'h0000D1);
    settle();
    expect_link("t3_body", 1'b1, 3'b001, 2'd0, flit(B, 8'd0, 24'h0000D1));
    tick();
    f0 = flit(T, 8'd0, 24'h0000DF);
    settle();
    expect_link("t3_tail", 1'b1, 3'b001, 2'd0, flit(T, 8'd0, 24'h0000DF));
    tick();
    vc_valid = 3'b100;
    settle();
    expect_link("t3_next", 1'b1, 3'b100, 2'd2, flit(H, 8'd0, 24'h0000D2));
    check("t3_err_proto", 64'(err_proto), 64'(0));
    tick();

    // backpressure while locked: nothing consumed, data held, nothing lost
    vc_valid = 3'b001;
    f0 = flit(H, 8'd3, 24'h0000E0);
    settle();
    expect_link("t4_head", 1'b1, 3'b001, 2'd0, flit(H, 8'd3, 24'h0000E0));
    tick();
    f0 = flit(B, 8'd0, 24'h0000E1);
    link_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      expect_link("t4_stall", 1'b1, 3'b000, 2'd0, flit(B, 8'd0, 24'h0000E1));
      tick();
    end
    link_ready = 1'b1;
    settle();
    expect_link("t4_resume", 1'b1, 3'b001, 2'd0, flit(B, 8'd0, 24'h0000E1));
    tick();
    f0 = flit(T, 8'd0, 24'h0000EF);
    settle();
    expect_link("t4_tail", 1'b1, 3'b001, 2'd0, flit(T, 8'd0, 24'h0000EF));
    tick();
    vc_valid = 3'b010;
    f1 = flit(H, 8'd0, 24'h0000E9);
    settle();
    expect_link("t4_after", 1'b1, 3'b010, 2'd1, flit(H, 8'd0, 24'h0000E9));
    tick();

    // BODY in IDLE is masked and flags a protocol error
    reset_pulse();
    vc_valid = 3'b010;
    f1 = flit(B, 8'd0, 24'h0000F1);
    settle();
    expect_link("t5_mask", 1'b0, 3'b000, 2'd0, '0);
    check("t5_err_pre", 64'(err_proto), 64'(0));
    tick();
    settle();
    check("t5_err_set", 64'(err_proto), 64'(1));
    check("t5_masked", 64'(link_valid), 64'(0));
    tick();
    vc_valid = 3'b011;
    f0 = flit(H, 8'd0, 24'h0000F0);
    settle();
    expect_link("t5_head", 1'b1, 3'b001, 2'd0, flit(H, 8'd0, 24'h0000F0));
    tick();

    // owner HEAD while locked, then reset mid-packet
    reset_pulse();
    settle();
    check("t6_err_clr", 64'(err_proto), 64'(0));
    vc_valid = 3'b001;
    f0 = flit(H, 8'd2, 24'h000A00);
    settle();
    expect_link("t6_head", 1'b1, 3'b001, 2'd0, flit(H, 8'd2, 24'h000A00));
    tick();
    f0 = flit(H, 8'd5, 24'h000A01);
    settle();
    expect_link("t6_dup", 1'b1, 3'b001, 2'd0, flit(H, 8'd5, 24'h000A01));
    tick();
    settle();
    check("t6_err_set", 64'(err_proto), 64'(1));
    arst = 1'b1;
    settle();
    expect_link("t6_rst", 1'b0, 3'b000, 2'd0, '0);
    tick();
    arst     = 1'b0;
    vc_valid = 3'b010;
    f1 = flit(H, 8'd0, 24'h000A11);
    settle();
    expect_link("t6_idle", 1'b1, 3'b010, 2'd1, flit(H, 8'd0, 24'h000A11));
    check("t6_err_after", 64'(err_proto), 64'(0));
    tick();

`ifdef VC_LINK_ARB_WATCHDOG_EN
    // owner idle 3 cycles then 4 cycles with TIMEOUT_CYC=4
    reset_pulse();
    vc_valid = 3'b001;
    f0 = flit(H, 8'd2, 24'h000B00);
    settle();
    tick();
    vc_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      settle();
      tick();
    end
    vc_valid = 3'b001;
    f0 = flit(B, 8'd0, 24'h000B01);
    settle();
    check("wd_3idle", 64'(err_timeout), 64'(0));
    check("wd_body", 64'(vc_ready), 64'(3'b001));
    tick();
    vc_valid = 3'b000;
    for (int i = 0; i < 4; i++) begin
      settle();
      tick();
    end
    settle();
    check("wd_4idle", 64'(err_timeout), 64'(1));
    check("wd_lock_held", 64'(link_valid), 64'(0));
    check("wd_err_proto", 64'(err_proto), 64'(0));
    tick();
`else
    settle();
    check("wd_off", 64'(err_timeout), 64'(0));
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
